// File: rtl/mux_arbiter_2to1_pkg.sv
// mux_arbiter_2to1_pkg
//   Shared definitions for the two-requester port arbiter:
//   - arb_state_t : FSM state encoding (IDLE / OWN1 / OWN2)
//   - req_id_t    : requester identifiers used for the "last owner" record
//   - BYTE_W      : width of the shared datapath byte
package mux_arbiter_2to1_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN1 = 2'b01,
        OWN2 = 2'b10
    } arb_state_t;

    // Requester identifiers; REQ2 is the reset value of "last" so that
    // requester 1 wins the first tie after reset.
    typedef enum logic {
        REQ1 = 1'b0,
        REQ2 = 1'b1
    } req_id_t;

endpackage

// File: rtl/mux8bit.sv
// mux8bit
//   Plain 2:1 byte multiplexer used as the data steer of the arbiter.
//   Ports:
//     in1 : byte selected when sel = 0
//     in2 : byte selected when sel = 1
//     sel : select
//     out : selected byte (purely combinational)
module mux8bit
    import mux_arbiter_2to1_pkg::*;
(
    input  logic [BYTE_W-1:0] in1,
    input  logic [BYTE_W-1:0] in2,
    input  logic              sel,
    output logic [BYTE_W-1:0] out
);

    assign out = sel ? in2 : in1;

endmodule

// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1
//   Round-robin arbiter sharing one 8-bit port between requester 1
//   (instruction fetch) and requester 2 (data access). Bounds each owner's
//   burst to MAX_BURST accepted transfers when the other side is waiting,
//   and drives the select of the byte mux.
//
//   Handshake: a requester raises reqX and holds it for its whole burst.
//   While it owns the port (gntX=1) every cycle with valid=1 and ack=1 is
//   one accepted transfer. valid = owner's gnt AND owner's req, so it falls
//   combinationally in the cycle the owner drops req; ack is ignored
//   whenever valid is low (including IDLE).
//
//   Ports:
//     clk, rst      : rising-edge clock, synchronous active-high reset
//     req1, req2    : port requests
//     in1, in2      : requester bytes
//     ack           : shared resource accepted the current byte
//     gnt1, gnt2    : registered grants (never both high)
//     sel           : registered mux select (0 = in1, 1 = in2)
//     out           : shared-port byte, combinational from sel
//     valid         : out carries a live byte
//     state_dbg     : current FSM state, for observation only
module mux_arbiter_2to1
    import mux_arbiter_2to1_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic              req2,
    input  logic [BYTE_W-1:0] in1,
    input  logic [BYTE_W-1:0] in2,
    input  logic              ack,
    output logic              gnt1,
    output logic              gnt2,
    output logic              sel,
    output logic [BYTE_W-1:0] out,
    output logic              valid,
    output arb_state_t        state_dbg
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    // cnt value at which the next accepted transfer completes the burst
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t        state;
    req_id_t           last;
    logic [CNT_W-1:0]  cnt;
    logic              xfer;
    logic              burst_done;

    assign valid      = (gnt1 & req1) | (gnt2 & req2);
    assign xfer       = valid & ack;
    assign burst_done = xfer && (cnt == CNT_LAST);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= REQ2;
            cnt   <= '0;
            gnt1  <= 1'b0;
            gnt2  <= 1'b0;
            sel   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Tie goes to whichever requester did not own last.
                    if (req1 && (!req2 || last == REQ2)) begin
                        state <= OWN1;
                        last  <= REQ1;
                        cnt   <= '0;
                        gnt1  <= 1'b1;
                        gnt2  <= 1'b0;
                        sel   <= 1'b0;
                    end else if (req2) begin
                        state <= OWN2;
                        last  <= REQ2;
                        cnt   <= '0;
                        gnt1  <= 1'b0;
                        gnt2  <= 1'b1;
                        sel   <= 1'b1;
                    end
                end

                OWN1: begin
                    // Dropping req1 blocks any transfer this cycle (valid=0),
                    // so release and preemption collapse to the same handover.
                    if ((!req1 || burst_done) && req2) begin
                        state <= OWN2;
                        last  <= REQ2;
                        cnt   <= '0;
                        gnt1  <= 1'b0;
                        gnt2  <= 1'b1;
                        sel   <= 1'b1;
                    end else if (!req1) begin
                        // sel keeps its value while idle
                        state <= IDLE;
                        cnt   <= '0;
                        gnt1  <= 1'b0;
                        gnt2  <= 1'b0;
                    end else if (burst_done) begin
                        // nobody waiting: restart the burst count, keep port
                        cnt   <= '0;
                    end else if (xfer) begin
                        cnt   <= cnt + 1'b1;
                    end
                end

                OWN2: begin
                    if ((!req2 || burst_done) && req1) begin
                        state <= OWN1;
                        last  <= REQ1;
                        cnt   <= '0;
                        gnt1  <= 1'b1;
                        gnt2  <= 1'b0;
                        sel   <= 1'b0;
                    end else if (!req2) begin
                        state <= IDLE;
                        cnt   <= '0;
                        gnt1  <= 1'b0;
                        gnt2  <= 1'b0;
                    end else if (burst_done) begin
                        cnt   <= '0;
                    end else if (xfer) begin
                        cnt   <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    gnt1  <= 1'b0;
                    gnt2  <= 1'b0;
                end
            endcase
        end
    end

    mux8bit u_mux (
        .in1 (in1),
        .in2 (in2),
        .sel (sel),
        .out (out)
    );

endmodule
